// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 scanned keypad front end with frame debounce and valid/ack key output
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_drv,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int               DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]       col_m, col_s;
  logic [DIV_W-1:0] div;
  logic             sample, frame_end;
  logic [1:0]       row_idx, first_col;
  logic [2:0]       pop, sum;
  logic [1:0]       acc_cnt, frame_cnt;
  logic [3:0]       acc_code, frame_code;
  state_t           state, state_next;
  logic [3:0]       cand, cand_next, cnt, cnt_next, cnt_inc;
  logic             raise;

  // Two-flop synchronizer for the asynchronous column returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= '0;
      col_s <= '0;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && row_drv[3];

  // Row dwell counter and one-hot row rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      row_drv <= 4'b0001;
    end else if (sample) begin
      div     <= '0;
      row_drv <= {row_drv[2:0], row_drv[3]};
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Row index of the strobed row and lowest pressed column on it
  always_comb begin
    row_idx = 2'd0;
    case (row_drv)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    first_col = 2'd0;
    if (col_s[3]) first_col = 2'd3;
    if (col_s[2]) first_col = 2'd2;
    if (col_s[1]) first_col = 2'd1;
    if (col_s[0]) first_col = 2'd0;
  end

  // Frame totals including the row being sampled now; count saturates at 2
  assign pop        = {2'b00, col_s[0]} + {2'b00, col_s[1]} + {2'b00, col_s[2]} + {2'b00, col_s[3]};
  assign sum        = {1'b0, acc_cnt} + pop;
  assign frame_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
  assign frame_code = (acc_cnt == 2'd0 && col_s != 4'd0) ? {row_idx, first_col} : acc_code;

  // Per-frame accumulator, cleared once the frame result has been consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (frame_end) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      acc_cnt  <= frame_cnt;
      acc_code <= frame_code;
    end
  end

  // Debounce FSM state, candidate code and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
    end
  end

  assign cnt_inc = cnt + 4'd1;

  // Next-state decision, taken only on a complete frame result
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    raise      = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_cnt == 2'd1) begin
            state_next = DEBOUNCE;
            cand_next  = frame_code;
            cnt_next   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (frame_cnt == 2'd1 && frame_code == cand) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_next = PRESSED;
              raise      = 1'b1;
            end
          end else if (frame_cnt == 2'd1) begin
            cand_next = frame_code;
            cnt_next  = 4'd1;
          end else begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end
        end
        PRESSED: begin
          if (frame_cnt == 2'd0) begin
            state_next = RELEASE;
            cnt_next   = 4'd1;
          end
        end
        RELEASE: begin
          if (frame_cnt == 2'd0) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_next = IDLE;
              cnt_next   = 4'd0;
            end
          end else begin
            state_next = PRESSED;
            cnt_next   = 4'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Key event handshake, overrun flag and held indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_held <= (state_next == PRESSED) || (state_next == RELEASE);
      if (raise) begin
        key_code  <= cand;
        key_valid <= 1'b1;
        if (key_valid && !key_ack) begin
          overrun <= 1'b1;
        end else if (key_ack) begin
          overrun <= 1'b0;
        end
      end else if (key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - frame-level self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_drv, col_in, key_code;
  logic        key_valid, key_ack, key_held, overrun;
  logic [15:0] key_mask;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row_drv(row_drv), .col_in(col_in),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: pressed keys on the strobed row drive their columns
  always_comb begin
    col_in = 4'd0;
    case (row_drv)
      4'b0001: col_in = key_mask[3:0];
      4'b0010: col_in = key_mask[7:4];
      4'b0100: col_in = key_mask[11:8];
      4'b1000: col_in = key_mask[15:12];
      default: col_in = 4'd0;
    endcase
  end

  typedef struct {
    logic [15:0] mask;
    int          reps;
    int          mode;
    logic        held;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_state;
  int         m_cnt;
  logic [3:0] m_cand;
  bit         m_held;
  bit         exp_ovr;
  bit         ack_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_cand = 0; m_held = 0; exp_ovr = 0;
    exp_q.delete();
  endtask

  // Frame-level reference: 0 idle, 1 debounce, 2 pressed, 3 release
  task automatic model_frame(input logic [15:0] m, input bit ack_at_end);
    int n;
    logic [3:0] c;
    bit ev;
    n = $countones(m);
    c = 0;
    ev = 0;
    for (int b = 15; b >= 0; b--) if (m[b]) c = 4'(b);
    case (m_state)
      0: if (n == 1) begin m_state = 1; m_cand = c; m_cnt = 1; end
      1: begin
        if (n == 1 && c == m_cand) begin
          m_cnt++;
          if (m_cnt == DEB) begin m_state = 2; ev = 1; end
        end else if (n == 1) begin
          m_cand = c; m_cnt = 1;
        end else begin
          m_state = 0; m_cnt = 0;
        end
      end
      2: if (n == 0) begin m_state = 3; m_cnt = 1; end
      default: begin
        if (n == 0) begin
          m_cnt++;
          if (m_cnt == DEB) begin m_state = 0; m_cnt = 0; end
        end else begin
          m_state = 2;
        end
      end
    endcase
    m_held = (m_state == 2) || (m_state == 3);
    if (ack_at_end) exp_ovr = 0;
    if (ev) begin
      if (exp_q.size() != 0) begin
        if (!ack_at_end) exp_ovr = 1;
        void'(exp_q.pop_front());
      end
      exp_q.push_back(c);
    end else if (ack_at_end && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // One full scan frame with mask held; mode 0 no ack, 1 ack after check, 2 ack on frame-end edge
  task automatic do_frame(input logic [15:0] m, input int mode);
    key_mask = m;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0 && ack_pending) begin
        key_ack = 1'b0;
        ack_pending = 0;
        check("ack_clears_valid", {31'd0, key_valid}, 32'd0);
        check("ack_clears_overrun", {31'd0, overrun}, 32'd0);
      end
      if (i == 14 && mode == 2) key_ack = 1'b1;
      if (i == 15 && mode == 2) key_ack = 1'b0;
    end
    model_frame(m, mode == 2);
    check("frame_align_row", {28'd0, row_drv}, 32'd1);
    check("key_held", {31'd0, key_held}, {31'd0, m_held});
    check("key_valid", {31'd0, key_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("key_code", {28'd0, key_code}, {28'd0, exp_q[0]});
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    if (mode == 1 && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_ovr = 0;
      key_ack = 1'b1;
      ack_pending = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_drv"}, {28'd0, row_drv}, 32'd1);
    check({tag, "_key_code"}, {28'd0, key_code}, 32'd0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_key_held"}, {31'd0, key_held}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus and checking
  initial begin
    rst = 1'b1; key_ack = 1'b0; key_mask = 16'd0; ack_pending = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 48; i++) begin
      check("scan_row", {28'd0, row_drv}, 32'(1 << ((i / 4) % 4)));
      check("scan_valid_low", {31'd0, key_valid}, 32'd0);
      check("scan_held_low", {31'd0, key_held}, 32'd0);
      @(negedge clk);
    end

    tbl.push_back('{16'h0200, 6, 1, 1'b1});
    tbl.push_back('{16'h0000, 3, 1, 1'b0});
    tbl.push_back('{16'h0200, 1, 1, 1'b0});
    tbl.push_back('{16'h0000, 1, 1, 1'b0});
    tbl.push_back('{16'h0200, 1, 1, 1'b0});
    tbl.push_back('{16'h0000, 3, 1, 1'b0});
    tbl.push_back('{16'h8001, 5, 1, 1'b0});
    tbl.push_back('{16'h0001, 3, 1, 1'b1});
    tbl.push_back('{16'h0000, 3, 1, 1'b0});
    tbl.push_back('{16'h0020, 3, 0, 1'b1});
    tbl.push_back('{16'h0000, 3, 0, 1'b0});
    tbl.push_back('{16'h0400, 2, 0, 1'b0});
    tbl.push_back('{16'h0400, 1, 1, 1'b1});
    tbl.push_back('{16'h0000, 3, 1, 1'b0});
    tbl.push_back('{16'h0020, 3, 0, 1'b1});
    tbl.push_back('{16'h0000, 3, 0, 1'b0});
    tbl.push_back('{16'h0400, 2, 0, 1'b0});
    tbl.push_back('{16'h0400, 1, 2, 1'b1});
    tbl.push_back('{16'h0000, 3, 1, 1'b0});
    tbl.push_back('{16'h0200, 3, 1, 1'b1});

    for (int v = 0; v < tbl.size(); v++) begin
      for (int r = 0; r < tbl[v].reps; r++) do_frame(tbl[v].mask, tbl[v].mode);
      check("vec_held_end", {31'd0, key_held}, {31'd0, tbl[v].held});
    end

    // Reset while key 9 is still held in PRESSED
    @(negedge clk);
    key_ack = 1'b0;
    ack_pending = 0;
    check("pre_reset_held", {31'd0, key_held}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midpress_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < 3; r++) do_frame(16'h0200, 1);
    check("post_reset_event_seen", {31'd0, ack_pending}, 32'd1);
    for (int r = 0; r < 3; r++) do_frame(16'h0000, 1);
    @(negedge clk);
    key_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
